if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
- Instruction prefetch buffer between the fetch stage and the IF/ID pipeline register / decode stage.
- Accepts {PC+4, instruction} pairs from fetch and presents them in order to decode with a valid/ready handshake.
- Decouples fetch from short decode stalls (hazard freeze, cache freeze).
- Discards all buffered entries on a taken branch (flush).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
DATA_W, 32, width of PC and instruction fields
CNT_W, 16, width of bubble performance counter

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  taken branch; discard all entries this cycle
in_valid  input  1  fetch presents a pair this cycle
in_pc  input  DATA_W  PC+4 of fetched instruction
in_instr  input  DATA_W  fetched instruction word
in_ready  output  1  queue can accept (not full)
out_valid  output  1  head entry available to decode
out_pc  output  DATA_W  head PC+4; 0 when empty
out_instr  output  DATA_W  head instruction; 0 (NOP) when empty
out_ready  input  1  decode consumes head (driven as !freeze && !cache_freeze)
count  output  $clog2(DEPTH)+1  current occupancy
bubble_cnt  output  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on clk rising edge). Reset clears read/write pointers, count=0, bubble_cnt=0. Outputs after the reset edge: out_valid=0, out_pc=0, out_instr=0, in_ready=1. Storage contents need not be cleared. Reset mid-operation drops all entries; it overrides flush, push and pop.
- Storage: circular buffer of DEPTH entries, each {pc, instr}. Write pointer and read pointer are log2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (count != DEPTH), purely from registered state. No combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_pc/out_instr read combinationally from the head entry, forced to 0 when count == 0.
- Latency: a pair pushed on edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass when empty.
- Simultaneous push and pop, with 0 < count < DEPTH: both happen; count unchanged; both pointers advance.
- Full (count==DEPTH): in_ready=0. A pop in that cycle frees a slot; push is accepted only from the next cycle.
- Empty: pop is impossible (out_valid=0). out_ready=1 in this state increments bubble_cnt.
- Flush, when rst=0: next state is empty (pointers equal, count=0). Flush has priority over push and pop in the same cycle, so an in-flight push is discarded. A pop on that cycle is still reported by out_valid/out_ready; decode handles it via its own flush. bubble_cnt is not affected by flush.
- bubble_cnt saturates at 2^CNT_W-1; it is cleared only by rst.
- No state machine beyond the pointers and count. Every update is a single registered next-state computed from (rst, flush, push, pop).

Decomposition:
- Shared package: DATA_W default and the NOP encoding constant (32'h0), shared with the IF/ID register and the hazard unit.
- One natural sub-module, pq_storage: DEPTH x (2*DATA_W) register array with one write port and one asynchronous read port.
- Pointers, count, handshake and the bubble counter stay in if_prefetch_queue.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_pc=0, out_instr=0, count=0, in_ready=1, bubble_cnt=0.
- Ordered fill/drain, out_ready=0: push pc=4/8/12/16 with instr=A0,A1,A2,A3 -> count=4, in_ready=0, out_pc=4. Then out_ready=1 -> outputs 4,8,12,16 on consecutive cycles, then out_valid=0.
- Full with simultaneous pop: count=4, in_valid=1 (pc=20), out_ready=1 -> that cycle the pop occurs and the push is rejected, count=3. Next cycle pc=20 is accepted, count=4.
- Steady stream: push and pop every cycle for 10 cycles starting from count=1 -> count stays 1. Pointers wrap past DEPTH with order preserved, out_pc increments by 4 each cycle.
- Flush: count=3, flush=1 with in_valid=1 (pc=100) -> next cycle count=0, out_valid=0, out_instr=0; pc=100 never appears at the output.
- Bubble counter: out_ready=1, queue empty for 5 cycles -> bubble_cnt=5. Preload to 16'hFFFF, hold empty -> bubble_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared fetch-side constants used by the prefetch queue, the IF/ID register and the hazard unit.
package if_prefetch_queue_pkg;
    localparam int          PQ_DATA_W = 32;
    localparam logic [31:0] PQ_NOP    = 32'h0;
endpackage

// File: rtl/if_prefetch_queue_pq_storage.sv
// Register array for the prefetch queue: one synchronous write port, one asynchronous read port.
module pq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    // Contents are never reset; occupancy tracking decides what is meaningful.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_prefetch_queue.sv
// In-order {PC+4, instruction} prefetch buffer between fetch and decode, with flush and
// a saturating count of decode-ready cycles that found the queue empty.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = PQ_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           bubble_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]    bub_q, bub_d;
    logic                push, pop;
    logic [2*DATA_W-1:0] head;

    // Handshake derives only from registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    pq_storage #(
        .DEPTH (DEPTH),
        .W     (2 * DATA_W)
    ) u_storage (
        .clk     (clk),
        .we_i    (push && !flush),
        .waddr_i (wr_q),
        .wdata_i ({in_pc, in_instr}),
        .raddr_i (rd_q),
        .rdata_o (head)
    );

    assign out_pc    = out_valid ? head[2*DATA_W-1:DATA_W] : '0;
    assign out_instr = out_valid ? head[DATA_W-1:0]        : DATA_W'(PQ_NOP);
    assign count      = cnt_q;
    assign bubble_cnt = bub_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        bub_d = bub_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (!push && pop) cnt_d = cnt_q - CW'(1);
        end
        // Bubble accounting ignores flush; it only stops at the saturation value.
        if (out_ready && !out_valid && (bub_q != '1)) begin
            bub_d = bub_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            bub_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            bub_q <= bub_d;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a queue-based scoreboard of expected head entries.
module tb_if_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;
    logic [15:0] bubble_cnt;

    logic        rst_s;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_instr;
    logic [2:0]  s_count;
    logic [2:0]  s_bubble;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] sb[$];
    int          mcount;
    logic [15:0] mbub;

    always #5 clk = ~clk;

    if_prefetch_queue #(.DEPTH(4), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
        .count(count), .bubble_cnt(bubble_cnt)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    if_prefetch_queue #(.DEPTH(4), .DATA_W(32), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst_s), .flush(1'b0),
        .in_valid(1'b0), .in_pc(32'h0), .in_instr(32'h0), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_pc(s_out_pc), .out_instr(s_out_instr), .out_ready(1'b1),
        .count(s_count), .bubble_cnt(s_bubble)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the scoreboard, update the scoreboard, advance.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        logic mpush, mpop;
        in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        #1;
        chk("in_ready", 64'(in_ready), 64'(mcount != 4));
        chk("out_valid", 64'(out_valid), 64'(mcount != 0));
        chk("count", 64'(count), 64'(mcount));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(mbub));
        if (mcount != 0) chk("head", {out_pc, out_instr}, sb[0]);
        else             chk("empty_head", {out_pc, out_instr}, 64'h0);
        mpush = iv && (mcount != 4);
        mpop  = ordy && (mcount != 0);
        if (ordy && mcount == 0 && mbub != 16'hFFFF) mbub++;
        if (fl) begin
            sb.delete();
        end else begin
            if (mpop)  void'(sb.pop_front());
            if (mpush) sb.push_back({pc, ins});
        end
        mcount = sb.size();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h55; in_instr = 32'hDEAD;
        sb.delete(); mcount = 0; mbub = 16'h0;

        // Reset held two cycles while fetch is presenting data.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_pc", 64'(out_pc), 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_bubble", 64'(bubble_cnt), 64'h0);

        // Ordered fill with decode stalled, then drain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * (i + 1)), 32'hA0 + 32'(i), 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("full_out_pc", 64'(out_pc), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(out_pc), 64'(4 * (i + 1)));
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("drained_valid", 64'(out_valid), 64'h0);

        // Full queue with simultaneous pop: push rejected, then accepted next cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * (i + 1)), 32'hB0 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'd20, 32'hB4, 1'b1, 1'b0);
        chk("fullpop_count", 64'(count), 64'd3);
        cycle(1'b1, 32'd20, 32'hB4, 1'b0, 1'b0);
        chk("refill_count", 64'(count), 64'd4);

        // Drain to one entry, then stream push+pop so pointers wrap.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_start_pc", 64'(out_pc), 64'd20);
        for (int i = 0; i < 10; i++) begin
            chk("stream_pc", 64'(out_pc), 64'(20 + 4 * i));
            cycle(1'b1, 32'(24 + 4 * i), 32'hC0 + 32'(i), 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd1);
        end
        chk("stream_end_pc", 64'(out_pc), 64'd60);

        // Flush with an in-flight push and a pop on the same cycle.
        cycle(1'b1, 32'd64, 32'hD0, 1'b0, 1'b0);
        cycle(1'b1, 32'd68, 32'hD1, 1'b0, 1'b0);
        chk("preflush_count", 64'(count), 64'd3);
        cycle(1'b1, 32'd100, 32'hD2, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_instr", 64'(out_instr), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("no_pc100", 64'(out_pc == 32'd100), 64'h0);
        end

        // Bubble counter: fresh reset, decode ready on an empty queue for 5 cycles.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; sb.delete(); mcount = 0; mbub = 16'h0;
        chk("bub_rst", 64'(bubble_cnt), 64'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bub_five", 64'(bubble_cnt), 64'd5);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bub_flush_hold", 64'(bubble_cnt), 64'd5);

        // Saturation on the 3-bit instance.
        rst_s = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("sat_reach", 64'(s_bubble), 64'd7);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", 64'(s_bubble), 64'd7);
        chk("sat_valid", 64'(s_out_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
